nv_nvdla_cdp_dp_cvtout_join: RTL and testbench

- Sits directly downstream of the CDP cvtout info pipe (p3) and the cvtout data path.
- Joins the 15-bit data-info stream (d3) with the converted-data stream, one info word per data beat.
- Masks unused lanes, tags beat/cube boundaries, and counts beats.
- Drives the CDP-to-WDMA interface through a 2-entry skid buffer, so no upstream ready depends combinationally on downstream ready.

---
 rtl/nv_nvdla_cdp_dp_cvtout_join_pkg.sv | 32 +++
 rtl/nv_nvdla_cdp_skid2.sv | 58 +++++
 rtl/nv_nvdla_cdp_dp_cvtout_join.sv | 109 ++++++++++
 tb/tb_nv_nvdla_cdp_dp_cvtout_join.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_cdp_dp_cvtout_join_pkg.sv
// Shared CDP definitions for the cvtout join stage: the layout of the
// data-info word and the output payload format.
package nv_nvdla_cdp_dp_cvtout_join_pkg;

    localparam int INFO_W       = 15;

    // Bit positions inside the data-info word
    localparam int LANE_CNT_LSB = 0;
    localparam int LANE_CNT_MSB = 3;
    localparam int LAST_W_BIT   = 4;
    localparam int LAST_H_BIT   = 5;
    localparam int LAST_C_BIT   = 6;
    localparam int EOB_BIT      = 7;

    // Boundary tag prepended to the masked data on the WDMA side
    localparam int TAG_W        = 4;
    localparam int DEF_DATA_W   = 64;

    typedef struct packed {
        logic last_c;
        logic last_h;
        logic last_w;
        logic eob;
    } cvtout_tag_t;

    // Full output payload at the default 8x8 lane geometry
    typedef struct packed {
        cvtout_tag_t             tag;
        logic [DEF_DATA_W-1:0]   data;
    } cvtout_pd_t;

endpackage

// File: rtl/nv_nvdla_cdp_skid2.sv
// Generic 2-entry valid/ready skid FIFO. push_rdy depends only on the
// occupancy register, so there is no combinational path from pop_rdy
// back to the producer. Head entry drives the output.
module nv_nvdla_cdp_skid2 #(
    parameter int PD_W = 68
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            push_vld,
    output logic            push_rdy,
    input  logic [PD_W-1:0] push_pd,
    output logic            pop_vld,
    input  logic            pop_rdy,
    output logic [PD_W-1:0] pop_pd
);

    logic [1:0]      cnt;
    logic            head;
    logic            tail;
    logic [PD_W-1:0] mem [2];
    logic            push;
    logic            pop;

    assign push_rdy = (cnt != 2'd2);
    assign pop_vld  = (cnt != 2'd0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;
    assign pop_pd   = mem[head];

    // Occupancy and pointers; cleared by reset so contents are dropped at once
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
        end else begin
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Payload storage, written at the tail; not reset
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[tail] <= push_pd;
        end
    end

endmodule

// File: rtl/nv_nvdla_cdp_dp_cvtout_join.sv
// CDP cvtout join: pairs each converted-data beat with its info word,
// zeroes unused lanes, tags cube boundaries, counts beats and hands the
// result to WDMA through a 2-entry skid buffer.
module nv_nvdla_cdp_dp_cvtout_join
    import nv_nvdla_cdp_dp_cvtout_join_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                          nvdla_core_clk,
    input  logic                          nvdla_core_rstn,
    input  logic                          op_en,
    input  logic                          cvt_out_pvld,
    output logic                          cvt_out_prdy,
    input  logic [LANES*LANE_W-1:0]       cvt_out_pd,
    input  logic                          data_info_in_vld_d3,
    output logic                          data_info_in_rdy_d3,
    input  logic [INFO_W-1:0]             data_info_in_pd_d3,
    output logic                          cvtout_wr_pvld,
    input  logic                          cvtout_wr_prdy,
    output logic [LANES*LANE_W+TAG_W-1:0] cvtout_wr_pd,
    output logic [CNT_W-1:0]              beat_cnt,
    output logic                          layer_done
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int PD_W   = DATA_W + TAG_W;

    // Zero every lane whose index exceeds the last valid lane index.
    function automatic logic [DATA_W-1:0] mask_lanes(
        input logic [DATA_W-1:0] d,
        input logic [3:0]        m1
    );
        logic [DATA_W-1:0] r;
        r = d;
        for (int i = 0; i < LANES; i++) begin
            if (i > int'(m1)) begin
                r[i*LANE_W +: LANE_W] = '0;
            end
        end
        return r;
    endfunction

    logic [3:0]       lane_cnt_m1;
    logic [6:0]       info_rsvd_unused;
    cvtout_tag_t      tag_p0;
    logic [PD_W-1:0]  pd_p0;
    logic             both_vld;
    logic             join_rdy;
    logic             fire;
    logic             last_all;
    logic [CNT_W-1:0] beat_cnt_p1;
    logic             done_p1;

    assign lane_cnt_m1      = data_info_in_pd_d3[LANE_CNT_MSB:LANE_CNT_LSB];
    assign info_rsvd_unused = data_info_in_pd_d3[INFO_W-1:8];

    assign tag_p0.last_c = data_info_in_pd_d3[LAST_C_BIT];
    assign tag_p0.last_h = data_info_in_pd_d3[LAST_H_BIT];
    assign tag_p0.last_w = data_info_in_pd_d3[LAST_W_BIT];
    assign tag_p0.eob    = data_info_in_pd_d3[EOB_BIT];

    assign pd_p0 = {tag_p0, mask_lanes(cvt_out_pd, lane_cnt_m1)};

    // Both streams are consumed together; each side's ready waits on the other's valid
    assign both_vld            = cvt_out_pvld & data_info_in_vld_d3;
    assign cvt_out_prdy        = join_rdy & data_info_in_vld_d3;
    assign data_info_in_rdy_d3 = join_rdy & cvt_out_pvld;
    assign fire                = both_vld & join_rdy;
    assign last_all            = tag_p0.last_w & tag_p0.last_h & tag_p0.last_c;

    nv_nvdla_cdp_skid2 #(
        .PD_W (PD_W)
    ) u_skid (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push_vld        (both_vld),
        .push_rdy        (join_rdy),
        .push_pd         (pd_p0),
        .pop_vld         (cvtout_wr_pvld),
        .pop_rdy         (cvtout_wr_prdy),
        .pop_pd          (cvtout_wr_pd)
    );

    // p0 -> p1: beat counter; op_en restarts the layer, a same-cycle fire counts as the first beat
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            beat_cnt_p1 <= '0;
        end else if (op_en) begin
            beat_cnt_p1 <= fire ? CNT_W'(1) : '0;
        end else if (fire) begin
            beat_cnt_p1 <= beat_cnt_p1 + CNT_W'(1);
        end
    end

    // p0 -> p1: layer-done pulse on acceptance of the last w/h/c beat
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= fire & last_all;
        end
    end

    assign beat_cnt   = beat_cnt_p1;
    assign layer_done = done_p1;

endmodule

// File: tb/tb_nv_nvdla_cdp_dp_cvtout_join.sv
// Bench for the CDP cvtout join stage: directed vectors plus a queue model
// of the skid buffer, counter and done pulse.
module tb_nv_nvdla_cdp_dp_cvtout_join;

    logic        nvdla_core_clk      = 1'b0;
    logic        nvdla_core_rstn     = 1'b0;
    logic        op_en               = 1'b0;
    logic        cvt_out_pvld        = 1'b0;
    logic        cvt_out_prdy;
    logic [63:0] cvt_out_pd          = '0;
    logic        data_info_in_vld_d3 = 1'b0;
    logic        data_info_in_rdy_d3;
    logic [14:0] data_info_in_pd_d3  = '0;
    logic        cvtout_wr_pvld;
    logic        cvtout_wr_prdy      = 1'b0;
    logic [67:0] cvtout_wr_pd;
    logic [31:0] beat_cnt;
    logic        layer_done;

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    nv_nvdla_cdp_dp_cvtout_join dut (
        .nvdla_core_clk      (nvdla_core_clk),
        .nvdla_core_rstn     (nvdla_core_rstn),
        .op_en               (op_en),
        .cvt_out_pvld        (cvt_out_pvld),
        .cvt_out_prdy        (cvt_out_prdy),
        .cvt_out_pd          (cvt_out_pd),
        .data_info_in_vld_d3 (data_info_in_vld_d3),
        .data_info_in_rdy_d3 (data_info_in_rdy_d3),
        .data_info_in_pd_d3  (data_info_in_pd_d3),
        .cvtout_wr_pvld      (cvtout_wr_pvld),
        .cvtout_wr_prdy      (cvtout_wr_prdy),
        .cvtout_wr_pd        (cvtout_wr_pd),
        .beat_cnt            (beat_cnt),
        .layer_done          (layer_done)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          pushed = 0;
    int          popped = 0;
    logic [67:0] q [$];
    logic [31:0] exp_cnt  = '0;
    logic        exp_done = 1'b0;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected payload: {last_c,last_h,last_w,eob, data with lanes above lane_cnt_m1 cleared}
    function automatic logic [67:0] ref_pd(input logic [14:0] inf, input logic [63:0] d);
        logic [63:0] m;
        if (inf[3:0] >= 4'd7) begin
            m = '1;
        end else begin
            m = (64'd1 << (8 * (int'(inf[3:0]) + 1))) - 64'd1;
        end
        return {inf[6], inf[5], inf[4], inf[7], d & m};
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance the model, return at posedge+1
    task automatic cycle(input logic cv, input logic iv, input logic [63:0] d,
                         input logic [14:0] inf, input logic rdy, input logic op);
        logic exp_rdy;
        logic push;
        logic pop;
        cvt_out_pvld        = cv;
        data_info_in_vld_d3 = iv;
        cvt_out_pd          = d;
        data_info_in_pd_d3  = inf;
        cvtout_wr_prdy      = rdy;
        op_en               = op;
        @(negedge nvdla_core_clk);
        exp_rdy = (q.size() != 2);
        chk("cvt_out_prdy", {67'd0, cvt_out_prdy}, {67'd0, exp_rdy & iv});
        chk("info_rdy", {67'd0, data_info_in_rdy_d3}, {67'd0, exp_rdy & cv});
        chk("wr_pvld", {67'd0, cvtout_wr_pvld}, {67'd0, q.size() != 0});
        chk("beat_cnt", {36'd0, beat_cnt}, {36'd0, exp_cnt});
        chk("layer_done", {67'd0, layer_done}, {67'd0, exp_done});
        push = cv & iv & exp_rdy;
        pop  = (q.size() != 0) & rdy;
        if (pop) begin
            chk("wr_pd", cvtout_wr_pd, q[0]);
            void'(q.pop_front());
            popped++;
        end
        if (push) begin
            q.push_back(ref_pd(inf, d));
            pushed++;
        end
        exp_done = push & (inf[6:4] == 3'b111);
        if (op) begin
            exp_cnt = push ? 32'd1 : 32'd0;
        end else if (push) begin
            exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge nvdla_core_clk);
        #1;
        cvt_out_pvld        = 1'b0;
        data_info_in_vld_d3 = 1'b0;
        op_en               = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 64'd0, 15'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [14:0] inf;
        logic        cv;
        logic        iv;
        logic        rdy;
        int          c;

        // Reset state
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        chk("rst_wr_pvld", {67'd0, cvtout_wr_pvld}, 68'd0);
        chk("rst_beat_cnt", {36'd0, beat_cnt}, 68'd0);
        chk("rst_layer_done", {67'd0, layer_done}, 68'd0);
        chk("rst_cvt_prdy", {67'd0, cvt_out_prdy}, 68'd0);
        chk("rst_info_rdy", {67'd0, data_info_in_rdy_d3}, 68'd0);
        nvdla_core_rstn = 1'b1;

        // Single beat, all lanes
        cycle(1'b1, 1'b1, 64'h1122334455667788, 15'h007, 1'b1, 1'b0);
        chk("s1_pvld", {67'd0, cvtout_wr_pvld}, 68'd1);
        chk("s1_pd", cvtout_wr_pd, 68'h0_1122334455667788);
        chk("s1_cnt", {36'd0, beat_cnt}, 68'd1);
        idle();

        // Lane masking and tag bits
        cycle(1'b1, 1'b1, 64'h0807060504030201, 15'h002, 1'b1, 1'b0);
        chk("mask_m1_2", cvtout_wr_pd, 68'h0_0000000000030201);
        idle();
        cycle(1'b1, 1'b1, 64'h0807060504030201, 15'h090, 1'b1, 1'b0);
        chk("mask_m1_0_eob_lastw", cvtout_wr_pd, 68'h3_0000000000000001);
        idle();
        cycle(1'b1, 1'b1, 64'h0807060504030201, 15'h00F, 1'b1, 1'b0);
        chk("mask_m1_15", cvtout_wr_pd, 68'h0_0807060504030201);
        idle();
        cycle(1'b1, 1'b1, 64'h0807060504030201, 15'h7F05, 1'b1, 1'b0);
        chk("mask_rsvd_m1_5", cvtout_wr_pd, 68'h0_0000060504030201);
        idle();

        // Data waits three cycles for its info word
        repeat (3) cycle(1'b1, 1'b0, 64'hA5A5A5A5A5A5A5A5, 15'h007, 1'b1, 1'b0);
        chk("wait_no_fire_cnt", {36'd0, beat_cnt}, 68'd5);
        cycle(1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, 15'h007, 1'b1, 1'b0);
        chk("wait_fire_cnt", {36'd0, beat_cnt}, 68'd6);
        idle();

        // Layer-done pulse
        cycle(1'b1, 1'b1, 64'hDEADBEEFCAFEF00D, 15'h077, 1'b1, 1'b0);
        chk("done_hi", {67'd0, layer_done}, 68'd1);
        idle();
        chk("done_lo", {67'd0, layer_done}, 68'd0);

        // op_en with a same-cycle fire, then op_en alone
        cycle(1'b1, 1'b1, 64'h0102030405060708, 15'h007, 1'b1, 1'b1);
        chk("op_fire_cnt", {36'd0, beat_cnt}, 68'd1);
        idle();
        cycle(1'b0, 1'b0, 64'd0, 15'd0, 1'b1, 1'b1);
        chk("op_clear_cnt", {36'd0, beat_cnt}, 68'd0);

        // Backpressure: only two beats fit, then random traffic drains in order
        pushed = 0;
        popped = 0;
        cycle(1'b1, 1'b1, 64'h1111111111111111, 15'h007, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'h2222222222222222, 15'h003, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'h3333333333333333, 15'h007, 1'b0, 1'b0);
        chk("bp_two_accepted", {36'd0, beat_cnt}, 68'd2);
        c = 0;
        while ((pushed < 100 || q.size() != 0) && c < 3000) begin
            if (pushed < 100) begin
                cv  = ($urandom_range(0, 3) != 0);
                iv  = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                cv  = 1'b0;
                iv  = 1'b0;
                rdy = 1'b1;
            end
            d   = {$urandom, $urandom};
            inf = 15'($urandom);
            cycle(cv, iv, d, inf, rdy, 1'b0);
            c++;
        end
        chk("rand_pushed", 68'(pushed), 68'd100);
        chk("rand_popped", 68'(popped), 68'd100);
        idle();

        // Reset while the skid buffer is full
        cycle(1'b1, 1'b1, 64'h4444444444444444, 15'h007, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 64'h5555555555555555, 15'h007, 1'b0, 1'b0);
        chk("full_pvld", {67'd0, cvtout_wr_pvld}, 68'd1);
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        chk("async_rst_pvld", {67'd0, cvtout_wr_pvld}, 68'd0);
        chk("async_rst_cnt", {36'd0, beat_cnt}, 68'd0);
        q.delete();
        exp_cnt  = '0;
        exp_done = 1'b0;
        @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rstn = 1'b1;

        // Fresh traffic after reset
        cycle(1'b1, 1'b1, 64'h8877665544332211, 15'h007, 1'b1, 1'b0);
        chk("post_rst_pvld", {67'd0, cvtout_wr_pvld}, 68'd1);
        chk("post_rst_pd", cvtout_wr_pd, 68'h0_8877665544332211);
        chk("post_rst_cnt", {36'd0, beat_cnt}, 68'd1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
